// File: rtl/air_hockey_pkg.sv
// Shared air-hockey constants: field geometry, serve point, radii, AI state codes.
package air_hockey_pkg;

    localparam int unsigned POS_W          = 12;
    localparam int unsigned FIELD_X_MAX    = 979;
    localparam int unsigned FIELD_Y_MIN    = 43;
    localparam int unsigned FIELD_Y_MAX    = 726;
    localparam int unsigned FIELD_CENTER_X = 512;
    localparam int unsigned SERVE_POS_X    = 487;
    localparam int unsigned SERVE_POS_Y    = 362;
    localparam int unsigned BALL_R         = 10;
    localparam int unsigned MALLET_R       = 20;

    localparam logic [1:0] AI_HOME    = 2'd0;
    localparam logic [1:0] AI_DEFEND  = 2'd1;
    localparam logic [1:0] AI_ATTACK  = 2'd2;
    localparam logic [1:0] AI_RETREAT = 2'd3;

    // Saturate a 13-bit coordinate into [lo, hi] and return it as a field position.
    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W:0] v,
                                                   input logic [POS_W:0] lo,
                                                   input logic [POS_W:0] hi);
        logic [POS_W:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r[POS_W-1:0];
    endfunction

endpackage

// File: rtl/ai_player_ctl_step_tick_gen.sv
// Movement-rate divider: one-cycle tick every DIV enabled cycles; cleared while disabled.
module step_tick_gen #(
    parameter int unsigned DIV = 250000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ai_player_ctl.sv
// Computer opponent (player 2): picks a target from the ball position and steps
// the mallet toward it at a limited rate, retreating home after each hit.
module ai_player_ctl
    import air_hockey_pkg::*;
#(
    parameter int unsigned RADIUS_BALL    = BALL_R,
    parameter int unsigned PLAYERS_RADIUS = MALLET_R,
    parameter int unsigned STEP_DIV       = 250000,
    parameter int unsigned RETREAT_STEPS  = 40,
    parameter int unsigned HOME_X         = 900,
    parameter int unsigned HOME_Y         = 362,
    parameter int unsigned CENTER_X       = FIELD_CENTER_X,
    parameter int unsigned SERVE_X        = SERVE_POS_X,
    parameter int unsigned SERVE_Y        = SERVE_POS_Y
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] xpos_ball,
    input  logic [11:0] ypos_ball,
    output logic [11:0] xpos_player_2,
    output logic [11:0] ypos_player_2,
    output logic [1:0]  ai_state
);

    localparam int unsigned RW = (RETREAT_STEPS > 0) ? $clog2(RETREAT_STEPS + 1) : 1;
    localparam logic [12:0] X_MIN = 13'(CENTER_X + PLAYERS_RADIUS);
    localparam logic [12:0] X_MAX = 13'(FIELD_X_MAX - PLAYERS_RADIUS);
    localparam logic [12:0] Y_MIN = 13'(FIELD_Y_MIN + PLAYERS_RADIUS);
    localparam logic [12:0] Y_MAX = 13'(FIELD_Y_MAX - PLAYERS_RADIUS);
    localparam int unsigned CONTACT_R2 = (RADIUS_BALL + PLAYERS_RADIUS) * (RADIUS_BALL + PLAYERS_RADIUS);

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [11:0]   xpos_q, xpos_d;
    logic [11:0]   ypos_q, ypos_d;
    logic          tick;

    step_tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .tick   (tick)
    );

    // Squared centre distance; operands are at most 4095 apart so 26 bits never overflow.
    logic signed [12:0] dx_c, dy_c;
    logic signed [25:0] dx_w_c, dy_w_c, dx_sq_c, dy_sq_c;
    logic [25:0]        dist2_c;
    logic               contact_c;

    assign dx_c      = $signed({1'b0, xpos_ball}) - $signed({1'b0, xpos_q});
    assign dy_c      = $signed({1'b0, ypos_ball}) - $signed({1'b0, ypos_q});
    assign dx_w_c    = 26'(dx_c);
    assign dy_w_c    = 26'(dy_c);
    assign dx_sq_c   = dx_w_c * dx_w_c;
    assign dy_sq_c   = dy_w_c * dy_w_c;
    assign dist2_c   = $unsigned(dx_sq_c) + $unsigned(dy_sq_c);
    assign contact_c = dist2_c < 26'(CONTACT_R2);

    // Raw target per state; attack aims one ball radius behind the ball (goal side).
    logic [12:0] tx_raw_c, ty_raw_c;
    logic [11:0] tx_c, ty_c;

    always_comb begin
        tx_raw_c = 13'(HOME_X);
        ty_raw_c = 13'(HOME_Y);
        case (state_q)
            AI_DEFEND: begin
                ty_raw_c = {1'b0, ypos_ball};
            end
            AI_ATTACK: begin
                tx_raw_c = {1'b0, xpos_ball} + 13'(RADIUS_BALL);
                ty_raw_c = {1'b0, ypos_ball};
            end
            default: ;
        endcase
    end

    assign tx_c = clamp_pos(tx_raw_c, X_MIN, X_MAX);
    assign ty_c = clamp_pos(ty_raw_c, Y_MIN, Y_MAX);

    // Next state, retreat countdown and one-pixel stepping toward the current target.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        if (en) begin
            if (state_q == AI_RETREAT) begin
                if (tick) begin
                    rcnt_d = rcnt_q - RW'(1);
                    if (rcnt_q == RW'(1)) begin
                        state_d = AI_HOME;
                    end
                end
            end else if (contact_c) begin
                state_d = AI_RETREAT;
                rcnt_d  = RW'(RETREAT_STEPS);
            end else if (xpos_ball == 12'(SERVE_X) && ypos_ball == 12'(SERVE_Y)) begin
                state_d = AI_HOME;
            end else if (xpos_ball < 12'(CENTER_X)) begin
                state_d = AI_DEFEND;
            end else begin
                state_d = AI_ATTACK;
            end

            if (tick) begin
                if (xpos_q < tx_c) begin
                    xpos_d = xpos_q + 12'd1;
                end else if (xpos_q > tx_c) begin
                    xpos_d = xpos_q - 12'd1;
                end
                if (ypos_q < ty_c) begin
                    ypos_d = ypos_q + 12'd1;
                end else if (ypos_q > ty_c) begin
                    ypos_d = ypos_q - 12'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= AI_HOME;
            rcnt_q  <= '0;
            xpos_q  <= 12'(HOME_X);
            ypos_q  <= 12'(HOME_Y);
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
        end
    end

    assign xpos_player_2 = xpos_q;
    assign ypos_player_2 = ypos_q;
    assign ai_state      = state_q;

endmodule

// File: tb/tb_ai_player_ctl.sv
// Directed bench for ai_player_ctl with STEP_DIV=4, RETREAT_STEPS=5; stimulus driven and
// outputs sampled on the falling edge.
module tb_ai_player_ctl;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] xpos_ball;
    logic [11:0] ypos_ball;
    logic [11:0] xpos_player_2;
    logic [11:0] ypos_player_2;
    logic [1:0]  ai_state;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    ai_player_ctl #(
        .STEP_DIV      (4),
        .RETREAT_STEPS (5)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .en            (en),
        .xpos_ball     (xpos_ball),
        .ypos_ball     (ypos_ball),
        .xpos_player_2 (xpos_player_2),
        .ypos_player_2 (ypos_player_2),
        .ai_state      (ai_state)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic ball(input int x, input int y);
        xpos_ball = 12'(x);
        ypos_ball = 12'(y);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey, input int es);
        chk({tag, ".x"},     32'(xpos_player_2), ex);
        chk({tag, ".y"},     32'(ypos_player_2), ey);
        chk({tag, ".state"}, 32'(ai_state),      es);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        ball(487, 362);
        cyc(3);
        chk_pos("reset", 900, 362, 0);
        rst = 1'b0;

        // Ball at serve point: stay home.
        cyc(200);
        chk_pos("serve_idle", 900, 362, 0);

        // Ball on our left: defend, y tracks ball at one px per tick.
        ball(300, 500);
        cyc(1);   chk_pos("defend_enter", 900, 362, 1);
        cyc(3);   chk_pos("defend_tick1", 900, 363, 1);
        cyc(547); chk_pos("defend_t137", 900, 499, 1);
        cyc(1);   chk_pos("defend_t138", 900, 500, 1);
        cyc(20);  chk_pos("defend_hold", 900, 500, 1);

        // Ball in our half: attack toward (710,100).
        ball(700, 100);
        cyc(1);   chk_pos("attack_enter", 900, 500, 2);
        cyc(3);   chk_pos("attack_tick1", 899, 499, 2);
        cyc(756); chk_pos("attack_t190", 710, 310, 2);
        cyc(40);  chk_pos("attack_t200", 710, 300, 2);

        // Back to serve: return home.
        ball(487, 362);
        cyc(1);   chk_pos("home_enter", 710, 300, 0);
        cyc(759); chk_pos("home_reached", 900, 362, 0);

        // Distance exactly 30 is not contact.
        ball(870, 362);
        cyc(1);   chk_pos("dist30", 900, 362, 2);

        // Contact at distance 20: retreat for 5 ticks.
        ball(880, 362);
        cyc(1);   chk_pos("contact", 900, 362, 3);
        cyc(17);  chk_pos("retreat_hold", 900, 362, 3);
        cyc(1);   chk_pos("retreat_expire", 900, 362, 0);
        cyc(1);   chk_pos("recontact", 900, 362, 3);

        // Ball moves away during retreat: retreat still runs to completion.
        ball(300, 362);
        cyc(18);  chk_pos("retreat2_hold", 900, 362, 3);
        cyc(1);   chk_pos("retreat2_expire", 900, 362, 0);
        cyc(1);   chk_pos("defend_again", 900, 362, 1);

        // Target y below field: clamp to 63.
        ball(600, 10);
        cyc(1);    chk_pos("clamp_y_enter", 900, 362, 2);
        cyc(1299); chk_pos("clamp_y", 610, 63, 2);

        // Target x beyond field: clamp to 959.
        ball(1000, 362);
        cyc(1);    chk_pos("clamp_x_enter", 610, 63, 2);
        cyc(1499); chk_pos("clamp_x", 959, 362, 2);

        // Enable freeze mid-move.
        ball(300, 100);
        cyc(1);   chk_pos("freeze_pre_enter", 959, 362, 1);
        cyc(38);  chk_pos("freeze_pre", 949, 352, 1);
        cyc(2);
        en = 1'b0;
        ball(700, 100);
        cyc(50);  chk_pos("frozen", 949, 352, 1);
        ball(300, 100);
        en = 1'b1;
        cyc(3);   chk_pos("resume_no_tick", 949, 352, 1);
        cyc(1);   chk_pos("resume_tick", 948, 351, 1);

        // Reset mid-move with en low.
        rst = 1'b1;
        en  = 1'b0;
        cyc(1);   chk_pos("reset_mid", 900, 362, 0);
        rst = 1'b0;
        en  = 1'b1;
        ball(487, 362);
        cyc(4);   chk_pos("post_reset", 900, 362, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
